reflectance_scan_sequencer: RTL

Sequences one read of the 8-channel RC-discharge reflectance sensor bar on the shared `leds_array` tri-state bus. Each read runs charge, release, per-channel discharge timing and thresholding, then publishes a registered 8-bit line pattern with a one-cycle valid strobe. It sits between the sensor pins and the line-following PID and direction logic. It owns the bus direction and the IR emitter enable, and repeats scans at a fixed period while enabled.

---
 rtl/reflectance_pkg.sv | 13 +
 rtl/discharge_capture.sv | 52 +++++
 rtl/reflectance_scan_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reflectance_pkg.sv
// Shared types and constants for the reflectance sensor bar scan sequencer.
package reflectance_pkg;

  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHARGE  = 2'd1,
    MEASURE = 2'd2,
    EVAL    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/discharge_capture.sv
// One sensor channel: synchronizes the pin, detects its first low sample
// while armed and holds the timer value seen at that moment.
module discharge_capture #(
  parameter int TW             = 8,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pin,
  input  logic          clear,
  input  logic          arm,
  input  logic [TW-1:0] timer_value,
  output logic          hit,
  output logic          latched,
  output logic [TW-1:0] time_eff
);

  logic          sync_1;
  logic          sync_2;
  logic [TW-1:0] capture_time;

  // Two-flop synchronizer; idles high like a charged sensor line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
    end
  end

  assign hit = arm && !latched && !sync_2;

  // Latch the timer on the first low sample; later samples are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latched      <= 1'b0;
      capture_time <= '0;
    end else if (clear) begin
      latched      <= 1'b0;
      capture_time <= '0;
    end else if (hit) begin
      latched      <= 1'b1;
      capture_time <= timer_value;
    end
  end

  // A channel that never discharged reports the full timeout window.
  assign time_eff = latched ? capture_time : TW'(TIMEOUT_CYCLES);

endmodule

// File: rtl/reflectance_scan_sequencer.sv
// Runs periodic charge / release / discharge-timing scans of the 8-channel
// RC reflectance bar and publishes a thresholded line pattern.
module reflectance_scan_sequencer
  import reflectance_pkg::*;
#(
  parameter int CHARGE_CYCLES  = 500,
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int THRESHOLD      = 50000,
  parameter int SCAN_PERIOD    = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  inout  wire  [NUM_CH-1:0] leds_array,
  output logic              ir_enable,
  output logic [NUM_CH-1:0] direction_command,
  output logic              command_valid,
  output logic              busy,
  output logic              timeout_flag
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(CHARGE_CYCLES + 1);
  localparam int PW = $clog2(SCAN_PERIOD);

  if (SCAN_PERIOD < CHARGE_CYCLES + TIMEOUT_CYCLES + 2) begin : g_period_check
    $error("SCAN_PERIOD too short for CHARGE_CYCLES + TIMEOUT_CYCLES + 2");
  end

  scan_state_t       state;
  logic              bus_drive;
  logic [CW-1:0]     charge_cnt;
  logic [TW-1:0]     timer;
  logic [PW-1:0]     period_cnt;
  logic              charge_done;
  logic              measure_entry;
  logic              arm;
  logic              all_done;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_latched;
  logic [NUM_CH-1:0] dark;
  logic [TW-1:0]     ch_time [NUM_CH];

  // The bus is driven only from a registered enable, so reset releases it at once.
  assign leds_array = bus_drive ? '1 : 'z;

  assign charge_done   = (charge_cnt == CW'(CHARGE_CYCLES - 1));
  assign measure_entry = (state == CHARGE) && charge_done;
  assign arm           = (state == MEASURE);
  assign all_done      = &(ch_latched | ch_hit);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    discharge_capture #(
      .TW             (TW),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_capture (
      .clk         (clk),
      .reset_n     (reset_n),
      .pin         (leds_array[ch]),
      .clear       (measure_entry),
      .arm         (arm),
      .timer_value (timer),
      .hit         (ch_hit[ch]),
      .latched     (ch_latched[ch]),
      .time_eff    (ch_time[ch])
    );
  end

  // Classify each channel as dark when its discharge took at least THRESHOLD cycles.
  always_comb begin
    dark = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dark[i] = (ch_time[i] >= TW'(THRESHOLD));
    end
  end

  // Scan FSM with its counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      bus_drive         <= 1'b0;
      ir_enable         <= 1'b0;
      direction_command <= '0;
      command_valid     <= 1'b0;
      busy              <= 1'b0;
      timeout_flag      <= 1'b0;
      charge_cnt        <= '0;
      timer             <= '0;
      period_cnt        <= '0;
    end else begin
      command_valid <= 1'b0;
      if (!enable) begin
        period_cnt <= '0;
      end else if (period_cnt != '0) begin
        period_cnt <= period_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable && (period_cnt == '0)) begin
            state      <= CHARGE;
            bus_drive  <= 1'b1;
            ir_enable  <= 1'b1;
            busy       <= 1'b1;
            charge_cnt <= '0;
            period_cnt <= PW'(SCAN_PERIOD - 1);
          end
        end

        CHARGE: begin
          if (!enable) begin
            state     <= IDLE;
            bus_drive <= 1'b0;
            ir_enable <= 1'b0;
            busy      <= 1'b0;
          end else if (charge_done) begin
            state      <= MEASURE;
            bus_drive  <= 1'b0;
            charge_cnt <= '0;
            timer      <= '0;
          end else begin
            charge_cnt <= charge_cnt + 1'b1;
          end
        end

        MEASURE: begin
          if (!enable) begin
            state     <= IDLE;
            ir_enable <= 1'b0;
            busy      <= 1'b0;
          end else if (all_done || (timer == TW'(TIMEOUT_CYCLES - 1))) begin
            state <= EVAL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        EVAL: begin
          state     <= IDLE;
          ir_enable <= 1'b0;
          busy      <= 1'b0;
          if (enable) begin
            direction_command <= dark;
            timeout_flag      <= ~&ch_latched;
            command_valid     <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          bus_drive <= 1'b0;
          ir_enable <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
